// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// The in-flight record is sized for the widest register address the unit supports.
package fwd_pkg;

    localparam int MAX_REG_AW        = 8;
    localparam int FWD_DEPTH_DEFAULT = 3;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  is_load;
    } inflight_entry_t;

    // Select index encoding: 0 = no producer, k+1 = tracked entry k.
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FWD_SEL_W = fwd_sel_w(FWD_DEPTH_DEFAULT);

endpackage

// File: rtl/fwd_select.sv
// Per-operand youngest-producer priority encoder and operand mux.
// Reports a not-ready producer so the top can stall decode instead of using stale data.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_AW           = 5,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int SEL_W            = FWD_SEL_W
) (
    input  inflight_entry_t [FWD_DEPTH-1:0] i_entries,
    input  logic [REG_AW-1:0]               i_rs_addr,
    input  logic                            i_rs_used,
    input  logic [FWD_DEPTH*XLEN-1:0]       i_stage_data,
    input  logic [XLEN-1:0]                 i_regfile_data,
    output logic [XLEN-1:0]                 o_op_data,
    output logic                            o_op_fwd,
    output logic                            o_not_ready
);

    logic [SEL_W-1:0] w_sel;
    logic [XLEN-1:0]  w_fwd_data;
    logic             w_ready;
    logic             w_rs_live;
    logic             w_hit;

    // x0 is hard-wired to zero, so it never looks for a producer.
    assign w_rs_live = i_rs_used && (i_rs_addr != '0);

    // Scan oldest to youngest so the smallest matching index is the last to claim w_sel.
    always_comb begin
        w_sel = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (w_rs_live && i_entries[k].valid &&
                (i_entries[k].rd == MAX_REG_AW'(i_rs_addr))) begin
                w_sel = SEL_W'(k + 1);
            end
        end
    end

    // A load is only usable once it has reached the stage where its data returns.
    always_comb begin
        w_fwd_data = '0;
        w_ready    = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (w_sel == SEL_W'(k + 1)) begin
                w_fwd_data = i_stage_data[k*XLEN +: XLEN];
                w_ready    = !i_entries[k].is_load || (k >= LOAD_READY_STAGE);
            end
        end
    end

    assign w_hit       = (w_sel != '0);
    assign o_op_fwd    = w_hit && w_ready;
    assign o_not_ready = w_hit && !w_ready;
    assign o_op_data   = o_op_fwd ? w_fwd_data : i_regfile_data;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Multi-stage bypass and load-use hazard unit between decode and the ID/EX register.
// Tracks in-flight writes, resolves operands, stalls on unready loads and squashes on redirect.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_AW           = 5,
    parameter int NUM_RD_PORTS     = 2,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int CNT_W            = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           id_valid,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]              id_rd_addr,
    input  logic                           id_rd_wr_en,
    input  logic                           id_is_load,
    input  logic [NUM_RD_PORTS*XLEN-1:0]   regfile_data,
    input  logic [FWD_DEPTH*XLEN-1:0]      stage_data,
    input  logic                           redirect,
    output logic [NUM_RD_PORTS*XLEN-1:0]   op_data,
    output logic [NUM_RD_PORTS-1:0]        op_fwd,
    output logic                           stall_id,
    output logic                           squash_id,
    output logic [CNT_W-1:0]               stall_cycles
);

    localparam int SEL_W = fwd_sel_w(FWD_DEPTH);

    generate
        if (REG_AW > MAX_REG_AW) begin : g_bad_reg_aw
            $error("REG_AW exceeds the in-flight record address width");
        end
        if ((LOAD_READY_STAGE < 1) || (LOAD_READY_STAGE >= FWD_DEPTH)) begin : g_bad_lrs
            $error("LOAD_READY_STAGE must lie in [1, FWD_DEPTH-1]");
        end
    endgenerate

    inflight_entry_t [FWD_DEPTH-1:0] r_table;
    inflight_entry_t                 w_new_entry;
    logic [NUM_RD_PORTS-1:0]         w_not_ready;
    logic                            w_issue;
    logic [CNT_W-1:0]                r_stall_cycles;

    generate
        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
            fwd_select #(
                .XLEN             (XLEN),
                .REG_AW           (REG_AW),
                .FWD_DEPTH        (FWD_DEPTH),
                .LOAD_READY_STAGE (LOAD_READY_STAGE),
                .SEL_W            (SEL_W)
            ) u_select (
                .i_entries      (r_table),
                .i_rs_addr      (id_rs_addr[p*REG_AW +: REG_AW]),
                .i_rs_used      (id_rs_used[p]),
                .i_stage_data   (stage_data),
                .i_regfile_data (regfile_data[p*XLEN +: XLEN]),
                .o_op_data      (op_data[p*XLEN +: XLEN]),
                .o_op_fwd       (op_fwd[p]),
                .o_not_ready    (w_not_ready[p])
            );
        end
    endgenerate

    // A redirect kills the ID instruction, so there is nothing left to stall for.
    assign stall_id  = id_valid && !redirect && (|w_not_ready);
    assign squash_id = redirect && id_valid;
    assign w_issue   = id_valid && id_rd_wr_en && (id_rd_addr != '0) && !stall_id && !squash_id;

    always_comb begin
        w_new_entry = '0;
        if (w_issue) begin
            w_new_entry.valid   = 1'b1;
            w_new_entry.rd      = MAX_REG_AW'(id_rd_addr);
            w_new_entry.is_load = id_is_load;
        end
    end

    // Stages past ID never stall, so the table advances unconditionally every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_table <= '0;
        end else begin
            r_table[0] <= w_new_entry;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_table[k] <= r_table[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (stall_id && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed scenarios then randomized traffic,
// predicted by a history-of-issued-writes model and checked by an independent monitor.
module tb_fwd_hazard_unit;

    localparam int XLEN             = 32;
    localparam int REG_AW           = 5;
    localparam int NP               = 2;
    localparam int DEPTH            = 3;
    localparam int LOAD_READY_STAGE = 1;
    localparam int CNT_W            = 32;

    typedef struct packed {
        logic                  resetN;
        logic                  idValid;
        logic [NP-1:0]         rsUsed;
        logic [NP*REG_AW-1:0]  rsAddr;
        logic [REG_AW-1:0]     rdAddr;
        logic                  rdWrEn;
        logic                  isLoad;
        logic                  redirect;
        logic [NP*XLEN-1:0]    regfile;
        logic [DEPTH*XLEN-1:0] stage;
    } stim_t;

    typedef struct packed {
        logic [NP*XLEN-1:0] opData;
        logic [NP-1:0]      opFwd;
        logic               stall;
        logic               squash;
        logic [CNT_W-1:0]   stallCount;
        logic [31:0]        cycle;
    } exp_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              isLoad;
    } issue_t;

    logic                  clk;
    logic                  resetN;
    logic                  idValid;
    logic [NP*REG_AW-1:0]  idRsAddr;
    logic [NP-1:0]         idRsUsed;
    logic [REG_AW-1:0]     idRdAddr;
    logic                  idRdWrEn;
    logic                  idIsLoad;
    logic [NP*XLEN-1:0]    regfileData;
    logic [DEPTH*XLEN-1:0] stageData;
    logic                  redirect;
    logic [NP*XLEN-1:0]    opData;
    logic [NP-1:0]         opFwd;
    logic                  stallId;
    logic                  squashId;
    logic [CNT_W-1:0]      stallCycles;

    // history[a] is the write issued a+1 cycles ago, i.e. the instruction now 'a' stages past ID.
    issue_t           history[$];
    exp_t             expQ[$];
    stim_t            lastStim;
    exp_t             lastExp;
    logic             haveLast;
    logic [CNT_W-1:0] modelStallCount;
    int               cycleCount;
    int               checkCount;
    int               errorCount;

    fwd_hazard_unit #(
        .XLEN             (XLEN),
        .REG_AW           (REG_AW),
        .NUM_RD_PORTS     (NP),
        .FWD_DEPTH        (DEPTH),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .CNT_W            (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (resetN),
        .id_valid     (idValid),
        .id_rs_addr   (idRsAddr),
        .id_rs_used   (idRsUsed),
        .id_rd_addr   (idRdAddr),
        .id_rd_wr_en  (idRdWrEn),
        .id_is_load   (idIsLoad),
        .regfile_data (regfileData),
        .stage_data   (stageData),
        .redirect     (redirect),
        .op_data      (opData),
        .op_fwd       (opFwd),
        .stall_id     (stallId),
        .squash_id    (squashId),
        .stall_cycles (stallCycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t predict(stim_t s);
        exp_t e;
        logic anyBlocked;
        e            = '0;
        anyBlocked   = 1'b0;
        e.opData     = s.regfile;
        e.stallCount = modelStallCount;
        e.cycle      = 32'(cycleCount);
        for (int p = 0; p < NP; p++) begin
            logic [REG_AW-1:0] rs;
            rs = s.rsAddr[p*REG_AW +: REG_AW];
            if (s.rsUsed[p] && rs != '0) begin
                for (int age = 0; age < history.size(); age++) begin
                    if (history[age].valid && history[age].rd == rs) begin
                        if (!history[age].isLoad || age >= LOAD_READY_STAGE) begin
                            e.opFwd[p]                 = 1'b1;
                            e.opData[p*XLEN +: XLEN]   = s.stage[age*XLEN +: XLEN];
                        end else begin
                            anyBlocked = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
        e.squash = s.redirect && s.idValid;
        e.stall  = s.idValid && !s.redirect && anyBlocked;
        return e;
    endfunction

    // Advance the model by one clock using the previous cycle's predicted decisions.
    task automatic commitModel();
        issue_t rec;
        if (haveLast && lastStim.resetN) begin
            rec.valid  = lastStim.idValid && lastStim.rdWrEn && (lastStim.rdAddr != '0) &&
                         !lastExp.stall && !lastExp.squash;
            rec.rd     = lastStim.rdAddr;
            rec.isLoad = lastStim.isLoad;
            history.push_front(rec);
            if (history.size() > DEPTH) void'(history.pop_back());
            if (lastExp.stall && modelStallCount != '1) modelStallCount = modelStallCount + 1'b1;
        end
    endtask

    task automatic applyStimulus(stim_t s);
        exp_t e;
        resetN      = s.resetN;
        idValid     = s.idValid;
        idRsUsed    = s.rsUsed;
        idRsAddr    = s.rsAddr;
        idRdAddr    = s.rdAddr;
        idRdWrEn    = s.rdWrEn;
        idIsLoad    = s.isLoad;
        redirect    = s.redirect;
        regfileData = s.regfile;
        stageData   = s.stage;
        if (!s.resetN) begin
            history.delete();
            modelStallCount = '0;
        end
        e = predict(s);
        expQ.push_back(e);
        lastStim = s;
        lastExp  = e;
        haveLast = 1'b1;
    endtask

    task automatic step(stim_t s);
        @(posedge clk);
        commitModel();
        cycleCount++;
        #1;
        applyStimulus(s);
    endtask

    task automatic checkField(string name, logic [31:0] cyc, logic [63:0] got, logic [63:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic checkOutput(exp_t e);
        for (int p = 0; p < NP; p++) begin
            checkField($sformatf("op_data[%0d]", p), e.cycle,
                       64'(opData[p*XLEN +: XLEN]), 64'(e.opData[p*XLEN +: XLEN]));
            checkField($sformatf("op_fwd[%0d]", p), e.cycle, 64'(opFwd[p]), 64'(e.opFwd[p]));
        end
        checkField("stall_id", e.cycle, 64'(stallId), 64'(e.stall));
        checkField("squash_id", e.cycle, 64'(squashId), 64'(e.squash));
        checkField("stall_cycles", e.cycle, 64'(stallCycles), 64'(e.stallCount));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic stim_t nopStim();
        stim_t s;
        s        = '0;
        s.resetN = 1'b1;
        for (int p = 0; p < NP; p++) s.regfile[p*XLEN +: XLEN] = $urandom;
        for (int k = 0; k < DEPTH; k++) s.stage[k*XLEN +: XLEN] = $urandom;
        return s;
    endfunction

    function automatic stim_t readStim(logic [REG_AW-1:0] rs0, logic [REG_AW-1:0] rs1);
        stim_t s;
        s         = nopStim();
        s.idValid = 1'b1;
        s.rsUsed  = 2'b11;
        s.rsAddr[0 +: REG_AW]      = rs0;
        s.rsAddr[REG_AW +: REG_AW] = rs1;
        return s;
    endfunction

    function automatic stim_t writeStim(logic [REG_AW-1:0] rd, logic isLoad);
        stim_t s;
        s         = nopStim();
        s.idValid = 1'b1;
        s.rdAddr  = rd;
        s.rdWrEn  = 1'b1;
        s.isLoad  = isLoad;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s          = nopStim();
        s.idValid  = ($urandom_range(0, 9) != 0);
        s.rsUsed   = NP'($urandom);
        for (int p = 0; p < NP; p++) s.rsAddr[p*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        s.rdAddr   = REG_AW'($urandom_range(0, 7));
        s.rdWrEn   = ($urandom_range(0, 3) != 0);
        s.isLoad   = ($urandom_range(0, 2) == 0);
        s.redirect = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        checkCount = 0;
        errorCount = 0;
        cycleCount = 0;
        haveLast   = 1'b0;
        modelStallCount = '0;
        resetN = 1'b0; idValid = 1'b0; idRsAddr = '0; idRsUsed = '0; idRdAddr = '0;
        idRdWrEn = 1'b0; idIsLoad = 1'b0; regfileData = '0; stageData = '0; redirect = 1'b0;

        s = nopStim(); s.resetN = 1'b0;
        step(s); step(s);

        step(writeStim(5'd5, 1'b0));
        s = readStim(5'd5, 5'd0); s.rsUsed = 2'b01; s.stage[0 +: XLEN] = 32'h0000_0011;
        step(s);

        step(writeStim(5'd6, 1'b1));
        step(readStim(5'd6, 5'd3));
        s = readStim(5'd6, 5'd3); s.stage[XLEN +: XLEN] = 32'hDEAD_BEEF;
        step(s);

        step(writeStim(5'd7, 1'b0));
        step(writeStim(5'd8, 1'b0));
        step(writeStim(5'd7, 1'b0));
        s = readStim(5'd7, 5'd7); s.stage[0 +: XLEN] = 32'h1; s.stage[2*XLEN +: XLEN] = 32'h3;
        step(s);

        step(writeStim(5'd0, 1'b0));
        s = readStim(5'd0, 5'd0); s.regfile = '0;
        step(s);

        step(writeStim(5'd10, 1'b1));
        s = readStim(5'd10, 5'd10); s.redirect = 1'b1; s.rdAddr = 5'd11; s.rdWrEn = 1'b1;
        step(s);
        step(readStim(5'd11, 5'd10));

        step(writeStim(5'd9, 1'b0));
        step(writeStim(5'd9, 1'b0));
        step(writeStim(5'd9, 1'b0));
        s = readStim(5'd9, 5'd9); s.idValid = 1'b0; s.resetN = 1'b0;
        step(s);
        step(s);
        step(readStim(5'd9, 5'd9));

        for (int i = 0; i < 400; i++) step(randStim());

        @(posedge clk);
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain pending %0d expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
